can_crc_check: RTL and testbench

- Receive-side counterpart of the CAN 2.0 CRC generator.
- Takes sampled raw bus bits, removes stuff bits, and computes the CAN CRC-15 over SOF through the end of the data field.
- Captures the received 15-bit CRC sequence, compares it against the computed value, and checks the CRC delimiter.
- Sits between the bit-timing/sampling logic and the frame decoder. It feeds destuffed bits to the decoder and reports CRC and stuff errors to error handling.

---
 rtl/can_crc_check.sv | 176 +++++++++++++++++
 tb/tb_can_crc_check.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/can_crc_check.sv
// Receive-side CAN CRC-15 checker.
// Destuffs the sampled bus bits, runs the CRC-15 LFSR from SOF through the
// last data bit, captures the transmitted CRC sequence and checks it together
// with the CRC delimiter. Destuffed bits are forwarded to the frame decoder.
module can_crc_check #(
    parameter logic [14:0] CRC_POLY = 15'h4599,
    parameter int          LEN_W    = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_stb,
    input  logic             rx_bit,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             abort,
    output logic             dbit,
    output logic             dbit_vld,
    output logic [14:0]      crc,
    output logic [14:0]      crc_rx,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             stuff_err,
    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_CRC   = 2'd2;
    localparam logic [1:0] S_DELIM = 2'd3;

    logic [1:0]       state_reg,   state_next;
    logic [14:0]      crc_reg,     crc_next;
    logic [14:0]      crc_rx_reg,  crc_rx_next;
    logic [LEN_W-1:0] cnt_reg,     cnt_next;
    logic [2:0]       run_reg,     run_next;
    logic             last_reg,    last_next;
    logic [3:0]       idx_reg,     idx_next;
    logic             dbit_reg,    dbit_next;
    logic             vld_reg,     vld_next;
    logic             ok_reg,      ok_next;
    logic             err_reg,     err_next;
    logic             serr_reg,    serr_next;
    logic             busy_reg,    busy_next;

    logic [LEN_W-1:0] eff_len;
    logic [LEN_W-1:0] cnt_inc;
    logic [14:0]      crc_shift;

    // Derived helpers: zero length means CRC over SOF only; counter saturates.
    always_comb begin
        eff_len   = (frame_len == '0) ? LEN_W'(1) : frame_len;
        cnt_inc   = (&cnt_reg) ? cnt_reg : cnt_reg + LEN_W'(1);
        crc_shift = {crc_reg[13:0], 1'b0} ^ ((crc_reg[14] ^ rx_bit) ? CRC_POLY : 15'h0000);
    end

    // Next-state logic: destuffing, CRC accumulation, capture and final check.
    always_comb begin
        state_next  = state_reg;
        crc_next    = crc_reg;
        crc_rx_next = crc_rx_reg;
        cnt_next    = cnt_reg;
        run_next    = run_reg;
        last_next   = last_reg;
        idx_next    = idx_reg;
        dbit_next   = dbit_reg;
        vld_next    = 1'b0;
        ok_next     = 1'b0;
        err_next    = 1'b0;
        serr_next   = 1'b0;

        if (abort) begin
            state_next = S_IDLE;
        end else if (bit_stb) begin
            case (state_reg)
                S_IDLE: begin
                    if (!rx_bit) begin
                        // A dominant SOF shifted into a cleared LFSR leaves it at zero.
                        crc_next    = '0;
                        crc_rx_next = '0;
                        cnt_next    = LEN_W'(1);
                        run_next    = 3'd1;
                        last_next   = 1'b0;
                        idx_next    = 4'd0;
                        vld_next    = 1'b1;
                        dbit_next   = 1'b0;
                        state_next  = (eff_len == LEN_W'(1)) ? S_CRC : S_DATA;
                    end
                end
                S_DATA, S_CRC: begin
                    if (run_reg == 3'd5) begin
                        // Bit after five identical bits must be an opposite stuff bit.
                        if (rx_bit != last_reg) begin
                            run_next  = 3'd1;
                            last_next = rx_bit;
                        end else begin
                            serr_next  = 1'b1;
                            state_next = S_IDLE;
                        end
                    end else begin
                        run_next  = (rx_bit == last_reg) ? run_reg + 3'd1 : 3'd1;
                        last_next = rx_bit;
                        vld_next  = 1'b1;
                        dbit_next = rx_bit;
                        if (state_reg == S_DATA) begin
                            crc_next = crc_shift;
                            cnt_next = cnt_inc;
                            if (cnt_inc == eff_len) begin
                                state_next = S_CRC;
                                idx_next   = 4'd0;
                            end
                        end else begin
                            crc_rx_next = {crc_rx_reg[13:0], rx_bit};
                            idx_next    = idx_reg + 4'd1;
                            if (idx_reg == 4'd14) begin
                                state_next = S_DELIM;
                            end
                        end
                    end
                end
                S_DELIM: begin
                    if ((crc_rx_reg == crc_reg) && rx_bit) begin
                        ok_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                    state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end

        busy_next = (state_next != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            crc_reg    <= '0;
            crc_rx_reg <= '0;
            cnt_reg    <= '0;
            run_reg    <= 3'd0;
            last_reg   <= 1'b1;
            idx_reg    <= 4'd0;
            dbit_reg   <= 1'b1;
            vld_reg    <= 1'b0;
            ok_reg     <= 1'b0;
            err_reg    <= 1'b0;
            serr_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            crc_reg    <= crc_next;
            crc_rx_reg <= crc_rx_next;
            cnt_reg    <= cnt_next;
            run_reg    <= run_next;
            last_reg   <= last_next;
            idx_reg    <= idx_next;
            dbit_reg   <= dbit_next;
            vld_reg    <= vld_next;
            ok_reg     <= ok_next;
            err_reg    <= err_next;
            serr_reg   <= serr_next;
            busy_reg   <= busy_next;
        end
    end

    assign dbit      = dbit_reg;
    assign dbit_vld  = vld_reg;
    assign crc       = crc_reg;
    assign crc_rx    = crc_rx_reg;
    assign crc_ok    = ok_reg;
    assign crc_err   = err_reg;
    assign stuff_err = serr_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_can_crc_check.sv
// Directed bench for can_crc_check. Frames are built from data bits, the CRC
// is obtained by polynomial long division, the raw stream is bit-stuffed, and
// a compare process checks every cycle's pulses against the expectations set
// by the driver.
module tb_can_crc_check;

    localparam int LEN_W = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             bit_stb;
    logic             rx_bit;
    logic [LEN_W-1:0] frame_len;
    logic             abort;
    logic             dbit;
    logic             dbit_vld;
    logic [14:0]      crc;
    logic [14:0]      crc_rx;
    logic             crc_ok;
    logic             crc_err;
    logic             stuff_err;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int vld_cnt  = 0;

    logic exp_vld, exp_dbit, exp_ok, exp_err, exp_serr;

    can_crc_check #(.CRC_POLY(15'h4599), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_stb   (bit_stb),
        .rx_bit    (rx_bit),
        .frame_len (frame_len),
        .abort     (abort),
        .dbit      (dbit),
        .dbit_vld  (dbit_vld),
        .crc       (crc),
        .crc_rx    (crc_rx),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .stuff_err (stuff_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // CRC-15 as remainder of M(x)*x^15 divided by the generator polynomial.
    function automatic logic [14:0] crc15(input logic [63:0] data, input int n);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < n + 15; i++) begin
            r = {r[14:0], (i < n) ? data[i] : 1'b0};
            if (r[15]) r = r ^ 16'hC599;
        end
        return r[14:0];
    endfunction

    // Per-cycle comparison of the strobed outputs, one clock after each strobe.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                chk("dbit_vld", {31'd0, dbit_vld}, {31'd0, exp_vld});
                if (exp_vld) chk("dbit", {31'd0, dbit}, {31'd0, exp_dbit});
                chk("crc_ok", {31'd0, crc_ok}, {31'd0, exp_ok});
                chk("crc_err", {31'd0, crc_err}, {31'd0, exp_err});
                chk("stuff_err", {31'd0, stuff_err}, {31'd0, exp_serr});
                if (dbit_vld) vld_cnt++;
            end
        end
    end

    task automatic clr_exp();
        exp_vld = 0; exp_dbit = 0; exp_ok = 0; exp_err = 0; exp_serr = 0;
    endtask

    task automatic send_raw(input logic b, input logic ev, input logic ed,
                            input logic eo, input logic ee, input logic es);
        @(negedge clk);
        bit_stb = 1'b1; rx_bit = b;
        exp_vld = ev; exp_dbit = ed; exp_ok = eo; exp_err = ee; exp_serr = es;
        @(negedge clk);
        bit_stb = 1'b0; rx_bit = 1'b1;
        clr_exp();
    endtask

    // Build, stuff and send one frame; data[0] is SOF. flip corrupts the sent CRC.
    task automatic send_frame(input string nm, input logic [63:0] data, input int n,
                              input logic [LEN_W-1:0] flen, input logic [14:0] flip,
                              input logic delim);
        logic [79:0] fb;
        logic [14:0] c, cx;
        logic        last, good;
        int          run;
        c  = crc15(data, n);
        cx = c ^ flip;
        for (int i = 0; i < n; i++) fb[i] = data[i];
        for (int k = 0; k < 15; k++) fb[n + k] = cx[14 - k];
        frame_len = flen;
        vld_cnt = 0;
        last = 1'b1;
        run  = 0;
        for (int j = 0; j < n + 15; j++) begin
            if (j > 0 && run == 5) begin
                send_raw(!last, 0, 0, 0, 0, 0);
                last = !last;
                run  = 1;
            end
            if (j > 0 && fb[j] == last) run++;
            else run = 1;
            last = fb[j];
            send_raw(fb[j], 1, fb[j], 0, 0, 0);
        end
        good = (flip == 15'h0000) && delim;
        send_raw(delim, 0, 0, good, !good, 0);
        chk({nm, ".crc"}, {17'd0, crc}, {17'd0, c});
        chk({nm, ".crc_rx"}, {17'd0, crc_rx}, {17'd0, cx});
        chk({nm, ".vld_cnt"}, vld_cnt, n + 15);
        chk({nm, ".busy"}, {31'd0, busy}, 32'd0);
        $display("frame %s len=%0d crc=%h sent=%h delim=%0b expect_ok=%0b", nm, n, c, cx, delim, good);
    endtask

    initial begin
        rst_n = 1'b0; bit_stb = 1'b0; rx_bit = 1'b1; frame_len = '0; abort = 1'b0;
        clr_exp();
        repeat (3) @(negedge clk);
        chk("rst.crc", {17'd0, crc}, 32'd0);
        chk("rst.crc_rx", {17'd0, crc_rx}, 32'd0);
        chk("rst.dbit", {31'd0, dbit}, 32'd1);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.dbit_vld", {31'd0, dbit_vld}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Pin the reference CRC to the hand-computed value.
        chk("model.crc15", {17'd0, crc15(64'h2, 2)}, 32'h4599);

        send_frame("minimal", 64'h2, 2, 7'd2, 15'h0000, 1'b1);
        chk("minimal.lit_crc", {17'd0, crc}, 32'h4599);
        chk("minimal.lit_rx", {17'd0, crc_rx}, 32'h4599);
        chk("minimal.lit_vld", vld_cnt, 17);

        send_frame("badcrc", 64'h2, 2, 7'd2, 15'h0001, 1'b1);
        chk("badcrc.lit_rx", {17'd0, crc_rx}, 32'h4598);

        send_frame("zeros", 64'h0, 5, 7'd5, 15'h0000, 1'b1);
        chk("zeros.lit_crc", {17'd0, crc}, 32'h0);
        chk("zeros.lit_vld", vld_cnt, 20);

        send_frame("baddelim", 64'h2, 2, 7'd2, 15'h0000, 1'b0);
        send_frame("ones", 64'h0B0FE, 20, 7'd20, 15'h0000, 1'b1);
        send_frame("len0", 64'h0, 1, 7'd0, 15'h0000, 1'b1);

        // Stuff error: six dominant bits in a row.
        frame_len = 7'd20;
        for (int i = 0; i < 5; i++) send_raw(1'b0, 1, 0, 0, 0, 0);
        send_raw(1'b0, 0, 0, 0, 0, 1);
        chk("stuff.busy", {31'd0, busy}, 32'd0);
        $display("stuff error sequence done");

        // Abort mid-DATA, with a simultaneous strobe that must be ignored.
        frame_len = 7'd10;
        send_raw(1'b0, 1, 0, 0, 0, 0);
        send_raw(1'b1, 1, 1, 0, 0, 0);
        send_raw(1'b0, 1, 0, 0, 0, 0);
        @(negedge clk);
        abort = 1'b1; bit_stb = 1'b1; rx_bit = 1'b0;
        @(negedge clk);
        abort = 1'b0; bit_stb = 1'b0; rx_bit = 1'b1;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        $display("abort issued");
        send_frame("after_abort", 64'h2, 2, 7'd2, 15'h0000, 1'b1);

        // Asynchronous reset in the middle of the CRC field.
        frame_len = 7'd2;
        send_raw(1'b0, 1, 0, 0, 0, 0);
        send_raw(1'b1, 1, 1, 0, 0, 0);
        send_raw(1'b1, 1, 1, 0, 0, 0);
        send_raw(1'b0, 1, 0, 0, 0, 0);
        chk("midcrc.busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.crc", {17'd0, crc}, 32'd0);
        chk("midrst.crc_rx", {17'd0, crc_rx}, 32'd0);
        chk("midrst.dbit", {31'd0, dbit}, 32'd1);
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        chk("midrst.pulses", {28'd0, dbit_vld, crc_ok, crc_err, stuff_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset mid-CRC done");
        send_frame("post_reset", 64'h2, 2, 7'd2, 15'h0000, 1'b1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
